// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake plus the DUAL_PORT_RAM write/read port signals
// produced by ram_fifo_ctrl.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 1
);
    logic                  PUSH;
    logic [DATA_WIDTH-1:0] PUSH_DATA;
    logic                  POP;
    logic                  FULL;
    logic                  EMPTY;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic                  EN_WR;
    logic [ADDR_WIDTH-1:0] ADDR_WR;
    logic [DATA_WIDTH-1:0] D_IN;
    logic                  EN_RD;
    logic [ADDR_WIDTH-1:0] ADDR_RD;
    logic                  RD_VALID;

    modport master (
        output PUSH, PUSH_DATA, POP,
        input  FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW,
        input  EN_WR, ADDR_WR, D_IN, EN_RD, ADDR_RD, RD_VALID
    );

    modport slave (
        input  PUSH, PUSH_DATA, POP,
        output FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW,
        output EN_WR, ADDR_WR, D_IN, EN_RD, ADDR_RD, RD_VALID
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Circular-FIFO controller in front of a dual-port RAM: wrap-bit pointers,
// registered occupancy flags, sticky error flags and read-data valid tracking.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic             CLK,
    input  logic             RST,
    ram_fifo_ctrl_if.slave   bus
);
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic                push_acc, pop_acc;

    assign push_acc = bus.PUSH & ~bus.FULL;
    assign pop_acc  = bus.POP  & ~bus.EMPTY;

    always_comb begin
        wr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, push_acc};
        rd_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, pop_acc};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.COUNT     <= '0;
            bus.FULL      <= 1'b0;
            bus.EMPTY     <= 1'b1;
            bus.OVERFLOW  <= 1'b0;
            bus.UNDERFLOW <= 1'b0;
            bus.EN_WR     <= 1'b0;
            bus.ADDR_WR   <= '0;
            bus.D_IN      <= '0;
            bus.EN_RD     <= 1'b0;
            bus.ADDR_RD   <= '0;
            bus.RD_VALID  <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            // Flags come from the next pointers so they line up with COUNT.
            bus.COUNT <= wr_nxt - rd_nxt;
            bus.FULL  <= (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]) &&
                         (wr_nxt[ADDR_WIDTH] != rd_nxt[ADDR_WIDTH]);
            bus.EMPTY <= (wr_nxt == rd_nxt);

            bus.OVERFLOW  <= bus.OVERFLOW  | (bus.PUSH & bus.FULL);
            bus.UNDERFLOW <= bus.UNDERFLOW | (bus.POP  & bus.EMPTY);

            bus.EN_WR <= push_acc;
            if (push_acc) begin
                bus.ADDR_WR <= wr_ptr[ADDR_WIDTH-1:0];
                bus.D_IN    <= bus.PUSH_DATA;
            end

            bus.EN_RD <= pop_acc;
            if (pop_acc)
                bus.ADDR_RD <= rd_ptr[ADDR_WIDTH-1:0];

            // RAM read is registered: D_OUT is valid one edge after EN_RD.
            bus.RD_VALID <= bus.EN_RD;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized + directed bench for ram_fifo_ctrl with a queue-based model and
// a behavioural dual-port RAM checking the popped data stream.
module tb_ram_fifo_ctrl;
    localparam int DW = 4;
    localparam int AW = 1;
    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM attached to the controller's ports.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_dout = '0;
    always @(posedge CLK) begin
        if (bus.EN_WR) mem[bus.ADDR_WR] <= bus.D_IN;
        if (bus.EN_RD) ram_dout <= mem[bus.ADDR_RD];
    end

    // Reference model: FIFO contents as a queue, counters of accepted ops.
    logic [DW-1:0] q[$];
    int            wr_n, rd_n;
    bit            m_ovf, m_unf, m_en_wr, m_en_rd, m_rd_valid;
    int            m_addr_wr, m_addr_rd;
    logic [DW-1:0] m_d_in, m_pend, m_rd_data;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            q.delete();
            wr_n = 0; rd_n = 0;
            m_ovf = 0; m_unf = 0; m_en_wr = 0; m_en_rd = 0; m_rd_valid = 0;
            m_addr_wr = 0; m_addr_rd = 0; m_d_in = '0; m_pend = '0; m_rd_data = '0;
        end else begin
            bit pa, qa;
            pa = bus.PUSH && (q.size() < DEPTH);
            qa = bus.POP && (q.size() > 0);
            if (bus.PUSH && !pa) m_ovf = 1;
            if (bus.POP && !qa) m_unf = 1;
            m_rd_valid = m_en_rd;
            m_rd_data  = m_pend;
            m_en_wr = pa;
            m_en_rd = qa;
            if (qa) begin
                m_pend = q.pop_front();
                m_addr_rd = rd_n % DEPTH;
                rd_n++;
            end
            if (pa) begin
                q.push_back(bus.PUSH_DATA);
                m_addr_wr = wr_n % DEPTH;
                m_d_in = bus.PUSH_DATA;
                wr_n++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        chk("count",     32'(bus.COUNT),     32'(q.size()));
        chk("full",      32'(bus.FULL),      32'(q.size() == DEPTH));
        chk("empty",     32'(bus.EMPTY),     32'(q.size() == 0));
        chk("overflow",  32'(bus.OVERFLOW),  32'(m_ovf));
        chk("underflow", 32'(bus.UNDERFLOW), 32'(m_unf));
        chk("en_wr",     32'(bus.EN_WR),     32'(m_en_wr));
        chk("en_rd",     32'(bus.EN_RD),     32'(m_en_rd));
        chk("addr_wr",   32'(bus.ADDR_WR),   32'(m_addr_wr));
        chk("addr_rd",   32'(bus.ADDR_RD),   32'(m_addr_rd));
        chk("d_in",      32'(bus.D_IN),      32'(m_d_in));
        chk("rd_valid",  32'(bus.RD_VALID),  32'(m_rd_valid));
        if (m_rd_valid) chk("d_out", 32'(ram_dout), 32'(m_rd_data));
    end

    // Drive inputs, then let one posedge pass; outputs readable on return.
    task automatic cyc(input bit p, input logic [DW-1:0] d, input bit r);
        bus.PUSH = p; bus.PUSH_DATA = d; bus.POP = r;
        @(posedge CLK); #1;
    endtask

    initial begin
        bus.PUSH = 0; bus.PUSH_DATA = '0; bus.POP = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // Reset then idle
        repeat (3) cyc(0, 0, 0);
        chk("idle_empty", 32'(bus.EMPTY), 1);
        chk("idle_full",  32'(bus.FULL),  0);
        chk("idle_count", 32'(bus.COUNT), 0);
        chk("idle_en",    32'({bus.EN_WR, bus.EN_RD, bus.RD_VALID}), 0);

        // Fill with 3, 6
        cyc(1, 3, 0);
        chk("p1_en_wr", 32'(bus.EN_WR), 1);
        chk("p1_addr",  32'(bus.ADDR_WR), 0);
        chk("p1_d_in",  32'(bus.D_IN), 3);
        cyc(1, 6, 0);
        chk("p2_addr",  32'(bus.ADDR_WR), 1);
        chk("p2_d_in",  32'(bus.D_IN), 6);
        chk("p2_full",  32'(bus.FULL), 1);
        chk("p2_count", 32'(bus.COUNT), 2);

        // Push into full
        cyc(1, 9, 0);
        chk("ovf_en_wr", 32'(bus.EN_WR), 0);
        chk("ovf_flag",  32'(bus.OVERFLOW), 1);
        chk("ovf_count", 32'(bus.COUNT), 2);

        // Drain
        cyc(0, 0, 1);
        chk("pop1_addr", 32'(bus.ADDR_RD), 0);
        chk("pop1_rdv",  32'(bus.RD_VALID), 0);
        cyc(0, 0, 1);
        chk("pop2_addr", 32'(bus.ADDR_RD), 1);
        chk("pop1_rdv2", 32'(bus.RD_VALID), 1);
        chk("pop1_dout", 32'(ram_dout), 3);
        chk("pop2_empty", 32'(bus.EMPTY), 1);
        cyc(0, 0, 0);
        chk("pop2_rdv",  32'(bus.RD_VALID), 1);
        chk("pop2_dout", 32'(ram_dout), 6);

        // Pop while empty
        cyc(0, 0, 1);
        chk("unf_en_rd", 32'(bus.EN_RD), 0);
        chk("unf_flag",  32'(bus.UNDERFLOW), 1);
        chk("unf_count", 32'(bus.COUNT), 0);

        // Streaming across the wrap
        cyc(1, 0, 0);
        chk("pre_addr", 32'(bus.ADDR_WR), 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, DW'(k), 1);
            chk("str_count",   32'(bus.COUNT), 1);
            chk("str_addr_wr", 32'(bus.ADDR_WR), 32'(k % 2));
            chk("str_addr_rd", 32'((k - 1) % 2), 32'(bus.ADDR_RD));
        end
        cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);

        // Reset between a pop and its RD_VALID
        cyc(1, 7, 0);
        cyc(0, 0, 1);
        bus.POP = 0;
        #2 RST = 1;
        #1;
        chk("rst_rdv",   32'(bus.RD_VALID), 0);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        chk("rst_flags", 32'({bus.OVERFLOW, bus.UNDERFLOW, bus.FULL, bus.EN_RD}), 0);
        @(posedge CLK); #1 RST = 0;
        cyc(0, 0, 0);
        chk("rst_rdv2", 32'(bus.RD_VALID), 0);
        cyc(1, 5, 0);
        chk("rst_addr_wr", 32'(bus.ADDR_WR), 0);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                #2 RST = 1;
                #2 RST = 0;
            end
        end
        repeat (3) cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Upstream controller for the DUAL_PORT_RAM block. Converts a simple push/pop handshake into the RAM's write-port signals (EN_WR/ADDR_WR/D_IN) and read-port signals (EN_RD/ADDR_RD).
- Tracks occupancy with wrap-around pointers, so the RAM behaves as a circular FIFO.
- Flags full, empty and overflow/underflow.
- Flags the cycle when the RAM's D_OUT holds popped data.

Parameters:
- DATA_WIDTH, 4, width of push data and RAM word.
- ADDR_WIDTH, 1, RAM address width.
- DEPTH, 2, number of RAM entries; must equal 2**ADDR_WIDTH.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- PUSH  in  1  request to write PUSH_DATA.
- PUSH_DATA  in  DATA_WIDTH  data to store.
- POP  in  1  request to read the oldest entry.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  ADDR_WIDTH+1  current occupancy.
- OVERFLOW  out  1  sticky; a push was rejected because the FIFO was full.
- UNDERFLOW  out  1  sticky; a pop was rejected because the FIFO was empty.
- EN_WR  out  1  RAM write enable.
- ADDR_WR  out  ADDR_WIDTH  RAM write address.
- D_IN  out  DATA_WIDTH  RAM write data.
- EN_RD  out  1  RAM read enable.
- ADDR_RD  out  ADDR_WIDTH  RAM read address.
- RD_VALID  out  1  RAM D_OUT holds popped data this cycle.

Behaviour:
- Reset (RST high, async, any time including mid-operation):
  - wr_ptr = rd_ptr = 0, COUNT = 0, EMPTY = 1, FULL = 0.
  - OVERFLOW = UNDERFLOW = 0.
  - EN_WR = EN_RD = 0, ADDR_WR = ADDR_RD = 0, D_IN = 0, RD_VALID = 0.
  - In-flight pops are discarded: no RD_VALID after reset release.
- Internal pointers are ADDR_WIDTH+1 bits. The MSB is the wrap bit; the low ADDR_WIDTH bits form the address.
- Acceptance, evaluated on each posedge using pre-edge state:
  - push_acc = PUSH & !FULL.
  - pop_acc = POP & !EMPTY.
- On push_acc:
  - Register EN_WR = 1, ADDR_WR = wr_ptr[ADDR_WIDTH-1:0], D_IN = PUSH_DATA.
  - wr_ptr increments, wrapping modulo 2*DEPTH.
  - The RAM commits the word on the following edge, so write latency is 1 cycle after acceptance.
- On pop_acc:
  - Register EN_RD = 1, ADDR_RD = rd_ptr[ADDR_WIDTH-1:0].
  - rd_ptr increments.
- Outputs without acceptance: EN_WR/EN_RD return to 0 on any edge without the corresponding acceptance. ADDR_WR/ADDR_RD/D_IN hold their last values.
- RD_VALID:
  - RD_VALID(t+1) = EN_RD(t). The RAM read is registered, so RD_VALID is high exactly 2 edges after the POP is sampled.
  - One RD_VALID pulse per accepted pop, in order.
- COUNT update:
  - +1 on push_acc only.
  - −1 on pop_acc only.
  - Unchanged when both or neither are accepted.
- FULL/EMPTY are registered and consistent with COUNT in the same cycle.
- Simultaneous PUSH & POP:
  - Not full and not empty: both accepted; COUNT unchanged.
  - Full: pop accepted, push rejected, OVERFLOW set.
  - Empty: push accepted, pop rejected, UNDERFLOW set. The pushed word can be popped starting the next cycle.
- Write-before-read guarantee: an entry becomes poppable only once COUNT reflects it. The RAM write edge therefore always precedes or coincides with the RAM read edge of the pop. With DEPTH ≥ 2 this yields no read-during-write on the same address.
- OVERFLOW/UNDERFLOW stay set until RST.
- Wrap-around: after DEPTH pushes, ADDR_WR returns to 0. FULL is detected when the pointer low bits are equal and the wrap bits differ.

Test Plan:
- Reset then idle 3 cycles -> EMPTY=1, FULL=0, COUNT=0, EN_WR=EN_RD=RD_VALID=0.
- PUSH data 3 then 6 on consecutive cycles -> EN_WR high 2 cycles, ADDR_WR 0 then 1, D_IN 3 then 6; after the second push FULL=1, COUNT=2.
- From full, PUSH 9 -> EN_WR stays 0, OVERFLOW=1, COUNT=2. Then POP twice -> ADDR_RD 0 then 1; RD_VALID high 2 edges after each POP; RAM D_OUT 3 then 6; EMPTY=1.
- POP while empty -> EN_RD=0, UNDERFLOW=1, COUNT=0.
- Continuous streaming: 5 cycles of PUSH & POP with data 1..5 after one prefill push of 0 -> COUNT stays 1; ADDR_WR and ADDR_RD alternate 0/1 across the wrap; D_OUT sequence 0,1,2,3,4.
- Assert RST between a POP and its RD_VALID -> RD_VALID stays 0; all flags at reset values; a subsequent push writes ADDR_WR=0.
